// File: rtl/pc_sequencer_if.sv
// Fetch/decode/register-file bundle around the PC sequencer; the sequencer binds the master modport.
// Breakpoint signals exist only when PC_BKPT_EN is defined.
interface pc_sequencer_if;
    logic        imem_rdy;
    logic        dec_valid;
    logic [2:0]  dec_op;
    logic [2:0]  dec_cond;
    logic [8:0]  dec_off;
    logic        flag_n;
    logic        flag_v;
    logic        flag_z;
    logic [15:0] rs_data;
    logic [15:0] pc;
    logic        imem_req;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        redirect;
    logic        rf_hlt;
    logic        halted;
    logic [2:0]  dbg_state;
`ifdef PC_BKPT_EN
    logic        bkpt_en;
    logic [15:0] bkpt_addr;
    logic        bkpt_hit;

    modport master (
        input  imem_rdy, dec_valid, dec_op, dec_cond, dec_off, flag_n, flag_v, flag_z, rs_data,
               bkpt_en, bkpt_addr,
        output pc, imem_req, rf_we, rf_waddr, rf_wdata, redirect, rf_hlt, halted, dbg_state, bkpt_hit
    );
    modport slave (
        output imem_rdy, dec_valid, dec_op, dec_cond, dec_off, flag_n, flag_v, flag_z, rs_data,
               bkpt_en, bkpt_addr,
        input  pc, imem_req, rf_we, rf_waddr, rf_wdata, redirect, rf_hlt, halted, dbg_state, bkpt_hit
    );
`else
    modport master (
        input  imem_rdy, dec_valid, dec_op, dec_cond, dec_off, flag_n, flag_v, flag_z, rs_data,
        output pc, imem_req, rf_we, rf_waddr, rf_wdata, redirect, rf_hlt, halted, dbg_state
    );
    modport slave (
        output imem_rdy, dec_valid, dec_op, dec_cond, dec_off, flag_n, flag_v, flag_z, rs_data,
        input  pc, imem_req, rf_we, rf_waddr, rf_wdata, redirect, rf_hlt, halted, dbg_state
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: BOOT -> FETCH -> EXEC loop, DRAIN/HALTED after hlt.
// Optional PC breakpoint in FETCH when PC_BKPT_EN is defined.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int          DRAIN_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.master bus
);
    // Handshake: a fetch completes in a cycle where imem_req=1 and imem_rdy=1; an instruction
    // resolves in a cycle where the sequencer is in EXEC and dec_valid=1. Either side may stall.
    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_EXEC, S_DRAIN, S_HALTED} state_t;

    localparam int             CW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0]  DRAIN_LOAD = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          imem_req_q, imem_req_d;
    logic          rf_hlt_q, rf_hlt_d;
    logic          redirect_c, rf_we_c, taken;
    logic [15:0]   pc_inc, pc_rel;

    assign pc_inc = pc_q + 16'd1;
    assign pc_rel = pc_inc + {{7{bus.dec_off[8]}}, bus.dec_off};

    always_comb begin
        taken = 1'b0;
        case (bus.dec_cond)
            3'b000:  taken = !bus.flag_z;
            3'b001:  taken = bus.flag_z;
            3'b010:  taken = !bus.flag_z && !bus.flag_n;
            3'b011:  taken = bus.flag_n;
            3'b100:  taken = bus.flag_z || !bus.flag_n;
            3'b101:  taken = bus.flag_n || bus.flag_z;
            3'b110:  taken = bus.flag_v;
            default: taken = 1'b1;
        endcase
    end

`ifdef PC_BKPT_EN
    logic bkpt_hit_q, bkpt_hit_d;
    logic bkpt_now;
    assign bkpt_now = bus.bkpt_en && (pc_q == bus.bkpt_addr);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_c = 1'b0;
        rf_we_c    = 1'b0;
`ifdef PC_BKPT_EN
        bkpt_hit_d = bkpt_hit_q;
`endif
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
`ifdef PC_BKPT_EN
                if (bkpt_now) begin
                    bkpt_hit_d = 1'b1;
                    state_d    = (DRAIN_CYCLES == 0) ? S_HALTED : S_DRAIN;
                    cnt_d      = DRAIN_LOAD;
                end else if (bus.imem_rdy) begin
                    state_d = S_EXEC;
                end
`else
                if (bus.imem_rdy) state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (bus.dec_valid) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    case (bus.dec_op)
                        3'b001: if (taken) begin
                            pc_d       = pc_rel;
                            redirect_c = 1'b1;
                        end
                        3'b010: begin
                            pc_d       = pc_rel;
                            redirect_c = 1'b1;
                            rf_we_c    = 1'b1;
                        end
                        3'b011: begin
                            pc_d       = bus.rs_data;
                            redirect_c = 1'b1;
                        end
                        3'b100: begin
                            pc_d    = pc_q;
                            state_d = (DRAIN_CYCLES == 0) ? S_HALTED : S_DRAIN;
                            cnt_d   = DRAIN_LOAD;
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_HALTED;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_HALTED;
        endcase
    end

    // Request/halt flags are registered from the next state so they line up with the state they describe.
`ifdef PC_BKPT_EN
    assign imem_req_d = (state_d == S_FETCH) && !(bus.bkpt_en && (pc_d == bus.bkpt_addr));
`else
    assign imem_req_d = (state_d == S_FETCH);
`endif
    assign rf_hlt_d = (state_d == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            imem_req_q <= 1'b0;
            rf_hlt_q   <= 1'b0;
`ifdef PC_BKPT_EN
            bkpt_hit_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            imem_req_q <= imem_req_d;
            rf_hlt_q   <= rf_hlt_d;
`ifdef PC_BKPT_EN
            bkpt_hit_q <= bkpt_hit_d;
`endif
        end
    end

    // Link write and redirect describe the resolving EXEC cycle itself, so they decode live inputs.
    assign bus.pc        = pc_q;
    assign bus.imem_req  = imem_req_q;
    assign bus.rf_we     = rf_we_c;
    assign bus.rf_waddr  = 4'hF;
    assign bus.rf_wdata  = pc_inc;
    assign bus.redirect  = redirect_c;
    assign bus.rf_hlt    = rf_hlt_q;
    assign bus.halted    = rf_hlt_q;
    assign bus.dbg_state = state_q;
`ifdef PC_BKPT_EN
    assign bus.bkpt_hit  = bkpt_hit_q;
`endif
endmodule
